// File: rtl/fetch_mem_arbiter.sv
// Shares one memory port between instruction refills (I) and data accesses (D).
// Optional watchdog in BUSY is enabled by defining FETCH_MEM_ARB_TIMEOUT_EN.
module fetch_mem_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic [1:0]    fe_ctr,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          err,
  output logic [1:0]    dbg_state
);

  // Memory handshake: mem_req rises with address/controls and all of them
  // stay frozen until mem_ack is sampled high; mem_ack outside BUSY is ignored.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic       last;    // 1 = data side won the previous grant
  logic       owner;   // 1 = data side owns the current transaction
  logic       grant_d;
  logic       finish;
  logic       timeout;
  logic       i_finish;

`ifdef FETCH_MEM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || state != BUSY) cnt <= '0;
    else if (!mem_ack)        cnt <= cnt + CW'(1);
  end

  // Fires on the BUSY cycle that would make the un-acked count reach the limit.
  assign timeout = (state == BUSY) && !mem_ack && ((cnt + CW'(1)) == CW'(TIMEOUT_CYCLES));
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Ties go to whoever did not win last; a lone requester always wins.
  assign grant_d   = d_req && (!i_req || !last);
  assign finish    = (state == BUSY) && (mem_ack || timeout);
  assign i_finish  = finish && !owner;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
      fe_ctr    <= 2'b00;
    end else begin
      i_done <= i_finish;
      d_done <= finish && owner;
      err    <= finish && timeout;
      fe_ctr <= (i_req && !i_finish) ? 2'b10 : 2'b00;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state     <= BUSY;
            owner     <= grant_d;
            last      <= grant_d;
            mem_req   <= 1'b1;
            mem_we    <= grant_d && d_we;
            mem_addr  <= grant_d ? d_addr : i_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
          end
        end
        BUSY: begin
          if (finish) begin
            mem_req <= 1'b0;
            state   <= DONE;
            if (owner) d_rdata <= timeout ? '0 : mem_rdata;
            else       i_rdata <= timeout ? '0 : mem_rdata;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
Shares one backing-memory port between instruction-fetch refills (port I) and data-stage accesses (port D). Sequences each access as a request/ack transaction on the memory side and returns a one-cycle done pulse to the winning requester. Produces the 2-bit fetch-stage stall control, where 2'b10 means stall, so the PC holds while an instruction fetch is outstanding. Sits between the I-cache/fetch stage, the data stage and main memory.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT_CYCLES, 255, watchdog limit in BUSY; used only with the optional feature

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_req  in  1  instruction-side request, held until i_done
i_addr  in  AW  instruction address, byte address, word aligned
i_done  out  1  one-cycle pulse; i_rdata valid this cycle
i_rdata  out  DW  instruction read data
d_req  in  1  data-side request, held until d_done
d_we  in  1  1 = write, 0 = read
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_done  out  1  one-cycle completion pulse
d_rdata  out  DW  data read data; valid with d_done on reads
fe_ctr  out  2  fetch stall control: 2'b10 = stall, 2'b00 = run
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_ack  in  1  memory completion; mem_rdata valid same cycle
mem_rdata  in  DW  memory read data
err  out  1  one-cycle pulse with done when the transaction timed out

Behaviour:
- Reset state: state=IDLE, last=D, so I wins the first tie.
- Reset outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_done=0, d_done=0, i_rdata=0, d_rdata=0, err=0, fe_ctr=2'b00.
- All outputs are registered.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no req: stay in IDLE.
- IDLE, one req: grant that requester.
- IDLE, both req: grant the requester that is not `last`, then set last = the granted requester.
- IDLE -> BUSY on grant: latch owner, addr, we and wdata; mem_req=1 in the next cycle. I-side accesses always have mem_we=0.
- BUSY: mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ack is sampled high.
- BUSY, mem_ack=1: drop mem_req; register mem_rdata into the owner's rdata; go to DONE.
- DONE: owner's done=1 for exactly one cycle; next state IDLE.
- rdata holds its value until the next completion on that port.
- Minimum latency: req sampled in cycle 0, mem_req high in cycle 1, ack in cycle 1, done in cycle 2.
- Requester rule: deassert req in the cycle done is high. A req still high in the following IDLE cycle is treated as a new request.
- Requester dropping req mid-transaction: ignored; the transaction completes and done still pulses.
- mem_ack outside BUSY: ignored.
- fe_ctr = 2'b10 whenever i_req=1 and i_done has not yet pulsed for it, i.e. waiting in IDLE, owner in BUSY, or losing arbitration.
- fe_ctr = 2'b00 in the cycle i_done=1 and otherwise. Registered: it follows i_req with one cycle of lag.
- Fairness: under continuous contention, grants alternate I, D, I, D. No starvation.
- Reset mid-transaction: mem_req=0 in the next cycle and the transaction is discarded with no done pulse. The memory model must tolerate an abandoned request.

Optional Feature:
Macro FETCH_MEM_ARB_TIMEOUT_EN.
- Defined: an 8+ bit counter clears on BUSY entry and increments each BUSY cycle without ack. When count == TIMEOUT_CYCLES: drop mem_req, go to DONE, pulse owner's done with err=1, and set owner's rdata=0. A mem_ack arriving later is ignored.
- Not defined: BUSY waits indefinitely for mem_ack, err is tied 0 and no counter logic exists.

Test Plan:
- Reset, then i_req=1 with i_addr=0x00000004; mem acks on its first mem_req cycle with rdata=0xDEADBEEF -> mem_req high in cycle 1, i_done and i_rdata=0xDEADBEEF in cycle 2, fe_ctr=2'b10 in cycle 1 and 2'b00 in cycle 2.
- i_req and d_req both high from reset and held, 1-cycle ack each -> grant order I, D, I, D; each done is 3 cycles after the previous.
- D write: d_we=1, addr=0x100, wdata=0x12345678, ack delayed 5 cycles -> mem_we, mem_addr and mem_wdata stable for all 6 BUSY cycles; d_done one cycle after ack; i_rdata unchanged.
- I request held in BUSY for 3 cycles, rst pulsed for 1 cycle -> mem_req=0 in the next cycle, no i_done, all outputs at reset values, FSM in IDLE.
- d_req dropped one cycle after grant -> transaction still completes and d_done pulses once.
- With FETCH_MEM_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 BUSY cycles, done and err pulse together, rdata=0; a late mem_ack has no effect.
